gshare_bp: RTL and testbench

- Parametrised gshare direction predictor with a tagged direct-mapped BTB, sitting beside the fetch stage.
- Fetch issues a lookup per branch-candidate PC; the registered prediction returns one cycle later.
- EX resolves branches and trains the PHT and BTB.
- The global history register (GHR) updates speculatively at predict time and is repaired from an EX checkpoint on mispredict. This closes the history-lag gap of the previous generation.

---
 rtl/gshare_pkg.sv | 18 +
 rtl/bp_sat_ctr_array.sv | 43 ++++
 rtl/gshare_bp.sv | 195 +++++++++++++++++++
 tb/tb_gshare_bp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - counter encodings and saturating-counter step for gshare_bp
package gshare_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == ST) ? ST : ctr + 2'd1;
    end
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bp_sat_ctr_array.sv
// rtl/bp_sat_ctr_array.sv - PHT of 2-bit saturating counters, async reset,
// one combinational read port and one saturating-update write port
import gshare_pkg::*;

module bp_sat_ctr_array #(
  parameter int         IDX_W    = 8,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      ctr_d[wr_idx] = sat2_next(ctr_q[wr_idx], wr_taken);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

  // Read sees pre-write contents, so a same-cycle update never bypasses.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/gshare_bp.sv
// rtl/gshare_bp.sv - gshare predictor with tagged direct-mapped BTB and
// speculative GHR with EX repair; GSHARE_BP_STATS_EN adds event counters
import gshare_pkg::*;

module gshare_bp #(
  parameter int         XLEN      = 32,
  parameter int         IDX_W     = 8,
  parameter int         GHR_W     = 8,
  parameter int         BTB_IDX_W = 5,
  parameter int         TAG_W     = 10,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             lkp_valid,
  input  logic [XLEN-1:0]  lkp_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  output logic             pred_btb_hit,
  output logic [IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_mispredict,
`ifdef GSHARE_BP_STATS_EN
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispred,
`endif
  output logic [GHR_W-1:0] ghr
);

  localparam int BTB_DEPTH = 1 << BTB_IDX_W;

  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
    $error("gshare_bp: GHR_W must lie in 1..IDX_W");
  end
  if (BTB_IDX_W + TAG_W + 2 > XLEN) begin : g_bad_tag_w
    $error("gshare_bp: BTB_IDX_W+TAG_W+2 exceeds XLEN");
  end

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
  } btb_entry_t;

  btb_entry_t btb_q [BTB_DEPTH];
  btb_entry_t btb_d [BTB_DEPTH];

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [XLEN-1:0]  pred_target_q, pred_target_d;
  logic             pred_btb_hit_q, pred_btb_hit_d;
  logic [IDX_W-1:0] pred_idx_q, pred_idx_d;
  logic [GHR_W-1:0] pred_ghr_q, pred_ghr_d;

  logic [IDX_W-1:0]     lkp_pht_idx;
  logic [BTB_IDX_W-1:0] lkp_btb_idx;
  logic [TAG_W-1:0]     lkp_tag;
  btb_entry_t           lkp_entry;
  logic                 lkp_hit;
  logic                 lkp_taken;
  logic [XLEN-1:0]      lkp_target;
  logic [1:0]           pht_rd_ctr;
  logic                 unused_pc_bits;

  assign unused_pc_bits = ^{lkp_pc, upd_pc};

  bp_sat_ctr_array #(
    .IDX_W   (IDX_W),
    .CTR_INIT(CTR_INIT)
  ) u_pht (
    .clk     (clk),
    .Reset   (Reset),
    .rd_idx  (lkp_pht_idx),
    .rd_ctr  (pht_rd_ctr),
    .wr_en   (upd_valid),
    .wr_idx  (upd_idx),
    .wr_taken(upd_taken)
  );

  always_comb begin
    lkp_pht_idx = lkp_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    lkp_btb_idx = lkp_pc[BTB_IDX_W+1:2];
    lkp_tag     = lkp_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
    lkp_entry   = btb_q[lkp_btb_idx];
    lkp_hit     = lkp_entry.valid && (lkp_entry.tag == lkp_tag);
    // Never predict taken without a target to go to.
    lkp_taken   = pht_rd_ctr[1] && lkp_hit;
    lkp_target  = lkp_taken ? lkp_entry.target : lkp_pc + XLEN'(4);
  end

  always_comb begin
    pred_valid_d   = lkp_valid;
    pred_taken_d   = pred_taken_q;
    pred_target_d  = pred_target_q;
    pred_btb_hit_d = pred_btb_hit_q;
    pred_idx_d     = pred_idx_q;
    pred_ghr_d     = pred_ghr_q;
    if (lkp_valid) begin
      pred_taken_d   = lkp_taken;
      pred_target_d  = lkp_target;
      pred_btb_hit_d = lkp_hit;
      pred_idx_d     = lkp_pht_idx;
      pred_ghr_d     = ghr_q;
    end
  end

  // Repair from the EX checkpoint wins over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid && upd_mispredict) begin
      ghr_d = GHR_W'({upd_ghr, upd_taken});
    end else if (lkp_valid) begin
      ghr_d = GHR_W'({ghr_q, lkp_taken});
    end
  end

  always_comb begin
    btb_d = btb_q;
    if (upd_valid && upd_taken) begin
      btb_d[upd_pc[BTB_IDX_W+1:2]] = '{valid:  1'b1,
                                       tag:    upd_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2],
                                       target: upd_target};
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      ghr_q          <= '0;
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_target_q  <= '0;
      pred_btb_hit_q <= 1'b0;
      pred_idx_q     <= '0;
      pred_ghr_q     <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_q[i] <= '0;
      end
    end else begin
      ghr_q          <= ghr_d;
      pred_valid_q   <= pred_valid_d;
      pred_taken_q   <= pred_taken_d;
      pred_target_q  <= pred_target_d;
      pred_btb_hit_q <= pred_btb_hit_d;
      pred_idx_q     <= pred_idx_d;
      pred_ghr_q     <= pred_ghr_d;
      btb_q          <= btb_d;
    end
  end

  assign ghr          = ghr_q;
  assign pred_valid   = pred_valid_q;
  assign pred_taken   = pred_taken_q;
  assign pred_target  = pred_target_q;
  assign pred_btb_hit = pred_btb_hit_q;
  assign pred_idx     = pred_idx_q;
  assign pred_ghr     = pred_ghr_q;

`ifdef GSHARE_BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_updates_q, stat_updates_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_lookups_d = stat_lookups_q + 32'(lkp_valid);
    stat_updates_d = stat_updates_q + 32'(upd_valid);
    stat_mispred_d = stat_mispred_q + 32'(upd_valid && upd_mispredict);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      stat_lookups_q <= '0;
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      stat_lookups_q <= stat_lookups_d;
      stat_updates_q <= stat_updates_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

  assign stat_lookups = stat_lookups_q;
  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;
`endif

endmodule

// File: tb/tb_gshare_bp.sv
// tb/tb_gshare_bp.sv - directed self-checking bench for gshare_bp
module tb_gshare_bp;

  logic        clk;
  logic        Reset;
  logic        lkp_valid;
  logic [31:0] lkp_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_btb_hit;
  logic [7:0]  pred_idx;
  logic [7:0]  pred_ghr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [7:0]  upd_idx;
  logic [7:0]  upd_ghr;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [7:0]  ghr;

  int checks = 0;
  int errors = 0;

  gshare_bp dut (
    .clk           (clk),
    .Reset         (Reset),
    .lkp_valid     (lkp_valid),
    .lkp_pc        (lkp_pc),
    .pred_valid    (pred_valid),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_btb_hit  (pred_btb_hit),
    .pred_idx      (pred_idx),
    .pred_ghr      (pred_ghr),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_idx       (upd_idx),
    .upd_ghr       (upd_ghr),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .ghr           (ghr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [7:0] idx, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic mis, input logic [7:0] g);
    upd_valid = 1'b1; upd_idx = idx; upd_pc = pc; upd_taken = taken;
    upd_target = tgt; upd_mispredict = mis; upd_ghr = g;
    tick();
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lkp_valid = 1'b1; lkp_pc = pc;
    tick();
    lkp_valid = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1; lkp_valid = 1'b0; lkp_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_idx = '0; upd_ghr = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    #12;
    checks++; if ({pred_valid, pred_taken, pred_btb_hit} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000", {pred_valid, pred_taken, pred_btb_hit}); end
    checks++; if ({pred_target, pred_idx, pred_ghr, ghr} !== 56'h0) begin errors++;
      $display("FAIL reset_values: got %h expected 0", {pred_target, pred_idx, pred_ghr, ghr}); end
    @(posedge clk); #1; Reset = 1'b0;
    tick();
    checks++; if (pred_valid !== 1'b0) begin errors++;
      $display("FAIL reset_first_cycle_valid: got %b expected 0", pred_valid); end
  endtask

  task automatic test_lookup_miss;
    do_lookup(32'h100);
    checks++; if ({pred_valid, pred_taken, pred_btb_hit} !== 3'b100) begin errors++;
      $display("FAIL miss_flags: got %b expected 100", {pred_valid, pred_taken, pred_btb_hit}); end
    checks++; if (pred_target !== 32'h104) begin errors++;
      $display("FAIL miss_target: got %h expected 00000104", pred_target); end
    checks++; if (pred_idx !== 8'h40 || ghr !== 8'h00) begin errors++;
      $display("FAIL miss_idx_ghr: got idx %h ghr %h expected 40 00", pred_idx, ghr); end
    tick();
    checks++; if (pred_valid !== 1'b0 || pred_target !== 32'h104) begin errors++;
      $display("FAIL idle_hold: got valid %b target %h expected 0 00000104", pred_valid, pred_target); end
  endtask

  task automatic test_train;
    do_update(8'h40, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'h40, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    checks++; if (dut.u_pht.ctr_q[8'h40] !== 2'b11) begin errors++;
      $display("FAIL train_ctr: got %b expected 11", dut.u_pht.ctr_q[8'h40]); end
    do_lookup(32'h100);
    checks++; if ({pred_valid, pred_taken, pred_btb_hit} !== 3'b111) begin errors++;
      $display("FAIL train_flags: got %b expected 111", {pred_valid, pred_taken, pred_btb_hit}); end
    checks++; if (pred_target !== 32'h200) begin errors++;
      $display("FAIL train_target: got %h expected 00000200", pred_target); end
    checks++; if (ghr !== 8'h01) begin errors++;
      $display("FAIL train_ghr: got %h expected 01", ghr); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_ghr [4];
    exp_ghr[0] = 8'h00; exp_ghr[1] = 8'h01; exp_ghr[2] = 8'h03; exp_ghr[3] = 8'h07;
    do_update(8'h41, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'h43, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'h47, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'hFF, 32'h0, 1'b0, 32'h0, 1'b1, 8'h00);
    checks++; if (ghr !== 8'h00) begin errors++;
      $display("FAIL b2b_repair_zero: got %h expected 00", ghr); end
    lkp_valid = 1'b1; lkp_pc = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pred_taken !== 1'b1 || pred_ghr !== exp_ghr[i] || pred_idx !== (8'h40 ^ exp_ghr[i])) begin
        errors++;
        $display("FAIL b2b_pred_%0d: got taken %b ghr %h idx %h expected 1 %h %h",
                 i, pred_taken, pred_ghr, pred_idx, exp_ghr[i], 8'h40 ^ exp_ghr[i]);
      end
    end
    checks++; if (ghr !== 8'h0F) begin errors++;
      $display("FAIL b2b_ghr: got %h expected 0f", ghr); end
    upd_valid = 1'b1; upd_idx = 8'hFE; upd_pc = 32'h0; upd_taken = 1'b0;
    upd_mispredict = 1'b1; upd_ghr = 8'h03;
    tick();
    lkp_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    checks++; if (ghr !== 8'h06) begin errors++;
      $display("FAIL repair_ghr: got %h expected 06", ghr); end
    checks++; if (pred_valid !== 1'b1 || pred_ghr !== 8'h0F) begin errors++;
      $display("FAIL repair_same_cycle_lookup: got valid %b ghr %h expected 1 0f", pred_valid, pred_ghr); end
  endtask

  task automatic test_btb_conflict;
    do_update(8'h6C, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'h6C, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_lookup(32'h100);
    checks++; if (pred_btb_hit !== 1'b1 || pred_idx !== 8'h46 || ghr !== 8'h0C) begin errors++;
      $display("FAIL conflict_first: got hit %b idx %h ghr %h expected 1 46 0c", pred_btb_hit, pred_idx, ghr); end
    do_lookup(32'h100 + (32'd4 << 5));
    checks++; if ({pred_taken, pred_btb_hit} !== 2'b00 || pred_idx !== 8'h6C) begin errors++;
      $display("FAIL conflict_second: got taken %b hit %b idx %h expected 0 0 6c", pred_taken, pred_btb_hit, pred_idx); end
    checks++; if (pred_target !== 32'h184) begin errors++;
      $display("FAIL conflict_target: got %h expected 00000184", pred_target); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) do_update(8'h20, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    checks++; if (dut.u_pht.ctr_q[8'h20] !== 2'b00) begin errors++;
      $display("FAIL sat_low: got %b expected 00", dut.u_pht.ctr_q[8'h20]); end
    do_update(8'h20, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    checks++; if (dut.u_pht.ctr_q[8'h20] !== 2'b01) begin errors++;
      $display("FAIL sat_step_up: got %b expected 01", dut.u_pht.ctr_q[8'h20]); end
    do_update(8'h20, 32'h100, 1'b1, 32'h200, 1'b0, 8'h00);
    do_update(8'hFD, 32'h0, 1'b0, 32'h0, 1'b1, 8'h30);
    do_lookup(32'h100);
    checks++; if (pred_taken !== 1'b1 || pred_idx !== 8'h20 || pred_target !== 32'h200) begin errors++;
      $display("FAIL sat_lookup: got taken %b idx %h target %h expected 1 20 00000200",
               pred_taken, pred_idx, pred_target); end
  endtask

  task automatic test_reset_midstream;
    lkp_valid = 1'b1; lkp_pc = 32'h300;
    #2; Reset = 1'b1; #1;
    checks++; if ({pred_valid, pred_taken, pred_btb_hit} !== 3'b000 || pred_target !== 32'h0) begin errors++;
      $display("FAIL midreset_async: got %b target %h expected 000 0",
               {pred_valid, pred_taken, pred_btb_hit}, pred_target); end
    checks++; if ({pred_idx, pred_ghr, ghr} !== 24'h0) begin errors++;
      $display("FAIL midreset_idx_ghr: got %h expected 0", {pred_idx, pred_ghr, ghr}); end
    tick();
    lkp_valid = 1'b0; Reset = 1'b0;
    tick();
    checks++; if (pred_valid !== 1'b0) begin errors++;
      $display("FAIL midreset_dropped: got %b expected 0", pred_valid); end
    do_lookup(32'h100);
    checks++; if ({pred_valid, pred_taken, pred_btb_hit} !== 3'b100 || pred_target !== 32'h104) begin errors++;
      $display("FAIL midreset_first_lookup: got %b target %h expected 100 00000104",
               {pred_valid, pred_taken, pred_btb_hit}, pred_target); end
    checks++; if (dut.u_pht.ctr_q[8'h20] !== 2'b01) begin errors++;
      $display("FAIL midreset_ctr_init: got %b expected 01", dut.u_pht.ctr_q[8'h20]); end
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_train();
    test_back_to_back();
    test_btb_conflict();
    test_saturation();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
